// File: rtl/found_mon_pkg.sv
// found_mon_pkg: shared FSM state encodings and the saturating-increment
// helper used by the found-pulse burst monitor.
package found_mon_pkg;

  // Report channel states; encodings are fixed so the state can be probed on a bus.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REPORT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // Increment that sticks at maxVal; callers zero-extend narrower counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] maxVal);
    return (val >= maxVal) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/found_leaky_bucket.sv
// found_leaky_bucket: leaky-bucket accumulator fed by the found strobe.
// Each hit adds HIT_WEIGHT (saturating), each idle cycle leaks one unit.
// event_o flags a burst from the bucket level before this cycle's update.
module found_leaky_bucket #(
  parameter int BUCKET_W     = 8,
  parameter int HIT_WEIGHT   = 4,
  parameter int BURST_THRESH = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                found_i,
  output logic [BUCKET_W-1:0] bucket_o,
  output logic                event_o
);

  localparam logic [BUCKET_W:0] BUCKET_MAX = {1'b0, {BUCKET_W{1'b1}}};
  localparam logic [BUCKET_W:0] WEIGHT     = (BUCKET_W+1)'(HIT_WEIGHT);

  logic [BUCKET_W-1:0] bucket_q, bucket_d;
  logic [BUCKET_W:0]   sum;

  // Next bucket level: fill on a hit (clamped), leak on idle, never below zero.
  always_comb begin
    sum      = {1'b0, bucket_q} + WEIGHT;
    bucket_d = bucket_q;
    if (clr_i) begin
      bucket_d = '0;
    end else if (found_i) begin
      bucket_d = (sum > BUCKET_MAX) ? BUCKET_MAX[BUCKET_W-1:0] : sum[BUCKET_W-1:0];
    end else if (bucket_q != '0) begin
      bucket_d = bucket_q - BUCKET_W'(1);
    end
  end

  // Bucket level register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bucket_q <= '0;
    else       bucket_q <= bucket_d;
  end

  assign bucket_o = bucket_q;
  assign event_o  = found_i && (int'(bucket_q) >= BURST_THRESH);

endmodule

// File: rtl/found_burst_monitor.sv
// found_burst_monitor: counts detector hits, flags bursts via a leaky bucket
// and offers a hit-count snapshot to the host on a valid/ready channel with a
// post-accept holdoff. Define FOUND_BURST_CLR_EN to add the synchronous clr_i.
module found_burst_monitor
  import found_mon_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int BUCKET_W     = 8,
  parameter int HIT_WEIGHT   = 4,
  parameter int BURST_THRESH = 6,
  parameter int HOLDOFF_CYC  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef FOUND_BURST_CLR_EN
  input  logic                clr_i,
`endif
  input  logic                found_i,
  output logic [CNT_W-1:0]    hit_cnt_o,
  output logic [BUCKET_W-1:0] bucket_o,
  output logic                burst_o,
  output logic                report_valid_o,
  input  logic                report_ready_i,
  output logic [CNT_W-1:0]    report_data_o,
  output logic [CNT_W-1:0]    drop_cnt_o
);

  localparam logic [31:0]       CNT_MAX   = 32'({CNT_W{1'b1}});
  localparam int                HOLD_W    = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);

  logic                clr;
  logic                burstEvt;
  logic                dropEvt;
  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [CNT_W-1:0]    data_q, data_d;
  logic                burst_q, burst_d;

`ifdef FOUND_BURST_CLR_EN
  assign clr = clr_i;
`else
  assign clr = 1'b0;
`endif

  found_leaky_bucket #(
    .BUCKET_W     (BUCKET_W),
    .HIT_WEIGHT   (HIT_WEIGHT),
    .BURST_THRESH (BURST_THRESH)
  ) u_bucket (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr),
    .found_i  (found_i),
    .bucket_o (bucket_o),
    .event_o  (burstEvt)
  );

  // A burst that arrives while a report is outstanding or in holdoff is lost.
  assign dropEvt = burstEvt && (state_q != ST_IDLE);

  // Saturating hit/drop counters and the registered burst pulse; clear wins over hits.
  always_comb begin
    hit_d   = hit_q;
    drop_d  = drop_q;
    burst_d = burstEvt;
    if (found_i) hit_d  = CNT_W'(sat_inc(32'(hit_q), CNT_MAX));
    if (dropEvt) drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_MAX));
    if (clr) begin
      hit_d   = '0;
      drop_d  = '0;
      burst_d = 1'b0;
    end
  end

  // Report FSM next state: snapshot on an idle-time burst, hold until accepted,
  // then count down the holdoff before bursts are reported again.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (burstEvt) begin
          state_d = ST_REPORT;
          data_d  = hit_d;
        end
      end
      ST_REPORT: begin
        if (report_ready_i) begin
          if (HOLDOFF_CYC == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      ST_HOLDOFF: begin
        if (hold_q == '0) state_d = ST_IDLE;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d = ST_IDLE;
      hold_d  = '0;
      data_d  = '0;
    end
  end

  // State, counter and snapshot registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      hit_q   <= '0;
      drop_q  <= '0;
      data_q  <= '0;
      burst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hit_q   <= hit_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      burst_q <= burst_d;
    end
  end

  assign hit_cnt_o      = hit_q;
  assign burst_o        = burst_q;
  assign report_valid_o = (state_q == ST_REPORT);
  assign report_data_o  = data_q;
  assign drop_cnt_o     = drop_q;

endmodule
